// File: rtl/lift_fsm_controller.sv
// -----------------------------------------------------------------------------
// lift_fsm_controller
//
// Three-floor lift controller. Floor calls are latched into a pending mask and
// served with a direction-preference scheduler: when idle the lift keeps going
// the way it last went if there is work that way, otherwise it turns round.
// The door stays open for DOOR_CYCLES cycles and restarts its count whenever
// the current floor is called again.
//
// Parameters:
//   TRAVEL_CYCLES  clock cycles to move one floor (>= 1)
//   DOOR_CYCLES    clock cycles the door stays open after its last (re)start (>= 1)
//
// Ports:
//   clk          rising-edge system clock
//   rst_n        synchronous, active-low reset
//   req[2:0]     floor calls, sampled every edge (bit0 ground .. bit2 second)
//   estop        emergency stop (present only with LIFT_ESTOP_EN)
//   floor_state  one-hot current floor (001 / 010 / 100), registered
//   direction    10 up, 01 down, 00 stationary, registered
//   door_open    high while the door is open, registered
//   pending      latched, unserved calls, registered
//
// Build option:
//   LIFT_ESTOP_EN  adds the estop input. While estop is high the travel and
//                  door counters freeze, an idle lift does not depart, and
//                  calls keep latching. Undefined means estop is tied low.
//
// Handshake: none. req is a level input sampled on every rising edge; all
// outputs change only on rising edges.
// -----------------------------------------------------------------------------
module lift_fsm_controller #(
    parameter int TRAVEL_CYCLES = 8,
    parameter int DOOR_CYCLES   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] req,
`ifdef LIFT_ESTOP_EN
    input  logic       estop,
`endif
    output logic [2:0] floor_state,
    output logic [1:0] direction,
    output logic       door_open,
    output logic [2:0] pending
);

    localparam int TW = $clog2(TRAVEL_CYCLES + 1);
    localparam int DW = $clog2(DOOR_CYCLES + 1);

    localparam logic [TW-1:0] T_LAST = TW'(TRAVEL_CYCLES - 1);
    localparam logic [TW-1:0] T_MAX  = TW'(TRAVEL_CYCLES);
    localparam logic [DW-1:0] D_LAST = DW'(DOOR_CYCLES - 1);
    localparam logic [DW-1:0] D_MAX  = DW'(DOOR_CYCLES);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MOVE_UP   = 2'd1,
        MOVE_DOWN = 2'd2,
        DOOR_OPEN = 2'd3
    } state_t;

    state_t        state, state_n;
    logic [TW-1:0] tcnt, tcnt_n;
    logic [DW-1:0] dcnt, dcnt_n;
    logic          last_up, last_up_n;
    logic [2:0]    floor_n;
    logic [1:0]    direction_n;
    logic          door_n;
    logic [2:0]    pending_n;

    logic [2:0]    eff;       // latched calls plus calls arriving this edge
    logic [2:0]    serve;     // bits served this edge; cleared even if req'd now
    logic [2:0]    no_latch;  // req bits that are handled directly, not latched
    logic [2:0]    arrive;    // floor reached at the end of this travel step
    logic [2:0]    ahead;     // floors beyond 'arrive' in the travel direction
    logic          halt;

`ifdef LIFT_ESTOP_EN
    assign halt = estop;
`else
    assign halt = 1'b0;
`endif

    // Masks of floors strictly above / below a one-hot floor.
    function automatic logic [2:0] above_of(input logic [2:0] f);
        return {f[1] | f[0], f[0], 1'b0};
    endfunction

    function automatic logic [2:0] below_of(input logic [2:0] f);
        return {1'b0, f[2], f[2] | f[1]};
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            floor_state <= 3'b001;
            direction   <= 2'b00;
            door_open   <= 1'b0;
            pending     <= 3'b000;
            tcnt        <= '0;
            dcnt        <= '0;
            last_up     <= 1'b1;
        end else begin
            state       <= state_n;
            floor_state <= floor_n;
            direction   <= direction_n;
            door_open   <= door_n;
            pending     <= pending_n;
            tcnt        <= tcnt_n;
            dcnt        <= dcnt_n;
            last_up     <= last_up_n;
        end
    end

    always_comb begin
        state_n   = state;
        floor_n   = floor_state;
        tcnt_n    = tcnt;
        dcnt_n    = dcnt;
        last_up_n = last_up;
        serve     = 3'b000;
        no_latch  = 3'b000;
        arrive    = floor_state;
        ahead     = 3'b000;
        eff       = pending | req;

        case (state)
            IDLE: begin
                no_latch = floor_state;
                if (|(eff & floor_state)) begin
                    // A call at this floor opens the door on the very next edge.
                    state_n = DOOR_OPEN;
                    dcnt_n  = '0;
                    serve   = floor_state;
                end else if (!halt) begin
                    if (last_up && |(eff & above_of(floor_state))) begin
                        state_n   = MOVE_UP;
                        last_up_n = 1'b1;
                        tcnt_n    = '0;
                    end else if (|(eff & below_of(floor_state))) begin
                        state_n   = MOVE_DOWN;
                        last_up_n = 1'b0;
                        tcnt_n    = '0;
                    end else if (|(eff & above_of(floor_state))) begin
                        state_n   = MOVE_UP;
                        last_up_n = 1'b1;
                        tcnt_n    = '0;
                    end
                end
            end

            MOVE_UP, MOVE_DOWN: begin
                if (state == MOVE_UP) begin
                    arrive = {floor_state[1:0], 1'b0};
                    ahead  = above_of(arrive);
                end else begin
                    arrive = {1'b0, floor_state[2:1]};
                    ahead  = below_of(arrive);
                end
                if (!halt) begin
                    if (tcnt == T_LAST) begin
                        // Entry conditions guarantee a floor exists in the
                        // travel direction, so 'arrive' is always one-hot.
                        tcnt_n  = '0;
                        floor_n = arrive;
                        if (|(eff & arrive)) begin
                            state_n = DOOR_OPEN;
                            dcnt_n  = '0;
                            serve   = arrive;
                        end else if (|(eff & ahead)) begin
                            state_n = state;
                        end else begin
                            state_n = IDLE;
                        end
                    end else if (tcnt < T_MAX) begin
                        tcnt_n = tcnt + 1'b1;
                    end
                end
            end

            DOOR_OPEN: begin
                no_latch = floor_state;
                if (|(req & floor_state)) begin
                    // Re-call at this floor restarts the door time, even under estop.
                    dcnt_n = '0;
                    serve  = floor_state;
                end else if (!halt) begin
                    if (dcnt == D_LAST) begin
                        state_n = IDLE;
                        dcnt_n  = '0;
                    end else if (dcnt < D_MAX) begin
                        dcnt_n = dcnt + 1'b1;
                    end
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase

        pending_n = (pending | (req & ~no_latch)) & ~serve;

        case (state_n)
            MOVE_UP:   direction_n = 2'b10;
            MOVE_DOWN: direction_n = 2'b01;
            default:   direction_n = 2'b00;
        endcase
        door_n = (state_n == DOOR_OPEN);
    end

endmodule
